// File: rtl/cpu_io_responder_pkg.sv
// Shared constants and helpers for the CPU I/O responder.
// Holds the status/control bit layout and the snapshot width.
package cpu_io_responder_pkg;

    // Status word bit positions
    localparam int ST_OVF  = 15;
    localparam int ST_UNF  = 14;
    localparam int ST_SUNF = 13;

    // Control word bit positions (tos on a control write)
    localparam int CTL_CLR   = 0;
    localparam int CTL_FLUSH = 1;

    // Snapshot shifter width
    localparam int SNAP_W = 64;

    // Build the status word: sticky flags on top, occupancy in the low byte
    function automatic logic [15:0] make_status(
        input logic       ovf,
        input logic       unf,
        input logic       sunf,
        input logic [7:0] cnt
    );
        logic [15:0] w;
        w          = 16'h0000;
        w[ST_OVF]  = ovf;
        w[ST_UNF]  = unf;
        w[ST_SUNF] = sunf;
        w[7:0]     = cnt;
        return w;
    endfunction

endpackage

// File: rtl/cpu_io_responder_if.sv
// CPU I/O strobe bus: selects, strobes, write data and the read-back paths.
// master = CPU side, slave = peripheral side.
interface cpu_io_if;
    logic [10:0] op_sel;
    logic        rdReg;
    logic        wrReg;
    logic        wrEvt;
    logic        rdBit;
    logic [15:0] tos;
    logic [15:0] par_out;
    logic        ser_out;

    modport master (
        output op_sel, rdReg, wrReg, wrEvt, rdBit, tos,
        input  par_out, ser_out
    );

    modport slave (
        input  op_sel, rdReg, wrReg, wrEvt, rdBit, tos,
        output par_out, ser_out
    );
endinterface

// File: rtl/cpu_io_fifo_fwft.sv
// First-word-fall-through FIFO of 16-bit words with sticky overflow /
// underflow detection and a synchronous flush. The head word is always
// visible on 'head' so a pop can be answered in the strobe cycle.
module cpu_io_fifo_fwft #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     clr,
    input  logic [15:0]              din,
    output logic [15:0]              head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic          unf_r;

    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic          unf_set_s;

    // Accept/reject decisions; a pop frees the slot a full-FIFO push needs
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == CW'(DEPTH));
        pop_ok_s  = pop && !empty_s;
        push_ok_s = push && (!full_s || pop_ok_s);
        ovf_set_s = push && full_s && !pop_ok_s && !flush;
        unf_set_s = pop && empty_s && !flush;
    end

    // Storage write; no reset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a clear in the same cycle as a set wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign count = count_r;
    assign ovf   = ovf_r;
    assign unf   = unf_r;

endmodule

// File: rtl/cpu_io_responder.sv
// CPU I/O responder: answers rdReg/wrReg/wrEvt/rdBit strobes, pops producer
// words from a FWFT FIFO onto the par bus, reports status, and shifts a
// 64-bit snapshot out MSB first on the serial input.
module cpu_io_responder
    import cpu_io_responder_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int IRQ_LEVEL    = 8,
    parameter int RD_DATA_BIT  = 0,
    parameter int RD_STAT_BIT  = 1,
    parameter int WR_CTRL_BIT  = 0,
    parameter int EVT_SNAP_BIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    cpu_io_if.slave                cpu,
    input  logic [15:0]            din,
    input  logic                   din_vld,
    input  logic [SNAP_W-1:0]      snap,
    output logic [$clog2(DEPTH):0] count,
    output logic                   irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              rd_data_s;
    logic              rd_stat_s;
    logic              ctl_wr_s;
    logic              clr_s;
    logic              flush_s;
    logic              snap_ld_s;
    logic              bits_avail_s;

    logic [15:0]       head_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;
    logic              ovf_s;
    logic              unf_s;

    logic [SNAP_W-1:0] shreg_r;
    logic [6:0]        bits_left_r;
    logic              sunf_r;

    logic [15:0]       par_s;
    logic [15:0]       status_s;

    // Strobe/select decode
    always_comb begin
        rd_data_s    = cpu.rdReg && cpu.op_sel[RD_DATA_BIT];
        rd_stat_s    = cpu.rdReg && cpu.op_sel[RD_STAT_BIT];
        ctl_wr_s     = cpu.wrReg && cpu.op_sel[WR_CTRL_BIT];
        clr_s        = ctl_wr_s && cpu.tos[CTL_CLR];
        flush_s      = ctl_wr_s && cpu.tos[CTL_FLUSH];
        snap_ld_s    = cpu.wrEvt && cpu.op_sel[EVT_SNAP_BIT];
        bits_avail_s = (bits_left_r != 7'd0);
    end

    cpu_io_fifo_fwft #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_vld),
        .pop   (rd_data_s),
        .flush (flush_s),
        .clr   (clr_s),
        .din   (din),
        .head  (head_s),
        .empty (empty_s),
        .count (count_s),
        .ovf   (ovf_s),
        .unf   (unf_s)
    );

    // Read-back mux: data and status words are ORed when both are selected
    always_comb begin
        status_s = make_status(ovf_s, unf_s, sunf_r, 8'(count_s));
        par_s    = 16'h0000;
        if (rd_data_s && !empty_s) begin
            par_s = par_s | head_s;
        end else begin
            par_s = par_s;
        end
        if (rd_stat_s) begin
            par_s = par_s | status_s;
        end else begin
            par_s = par_s;
        end
    end

    // Snapshot shifter; a load beats a same-cycle serial read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r     <= {SNAP_W{1'b0}};
            bits_left_r <= 7'd0;
        end else if (snap_ld_s) begin
            shreg_r     <= snap;
            bits_left_r <= 7'd64;
        end else if (cpu.rdBit && bits_avail_s) begin
            shreg_r     <= {shreg_r[SNAP_W-2:0], 1'b0};
            bits_left_r <= bits_left_r - 7'd1;
        end else begin
            shreg_r     <= shreg_r;
            bits_left_r <= bits_left_r;
        end
    end

    // Serial underflow flag; cleared by the control write, clear wins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sunf_r <= 1'b0;
        end else if (clr_s) begin
            sunf_r <= 1'b0;
        end else if (cpu.rdBit && !bits_avail_s) begin
            sunf_r <= 1'b1;
        end else begin
            sunf_r <= sunf_r;
        end
    end

    assign cpu.par_out = par_s;
    assign cpu.ser_out = bits_avail_s ? shreg_r[SNAP_W-1] : 1'b0;
    assign count       = count_s;
    assign irq         = (count_s >= CW'(IRQ_LEVEL));

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed self-checking bench for cpu_io_responder (DEPTH=16, IRQ_LEVEL=8).
// Stimulus is applied 1 time unit after the rising edge; combinational
// read-back is sampled 1 unit later, well away from the edge.
module tb_cpu_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_vld;
    logic [63:0] snap;
    logic [4:0]  count;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_io_if bus ();

    cpu_io_responder #(
        .DEPTH     (16),
        .IRQ_LEVEL (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (bus),
        .din     (din),
        .din_vld (din_vld),
        .snap    (snap),
        .count   (count),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.op_sel = 11'h000;
        bus.rdReg  = 1'b0;
        bus.wrReg  = 1'b0;
        bus.wrEvt  = 1'b0;
        bus.rdBit  = 1'b0;
        bus.tos    = 16'h0000;
        din_vld    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        bus.rdReg  = 1'b1;
        bus.op_sel = 11'h003;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_par: got %h expected 0000", bus.par_out);
        end
        n_checks++;
        if (bus.ser_out !== 1'b0 || irq !== 1'b0 || count !== 5'd0) begin
            n_fail++; $display("FAIL reset_state: ser %b irq %b count %0d expected 0 0 0", bus.ser_out, irq, count);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        n_checks++;
        if (count !== 5'd0) begin
            n_fail++; $display("FAIL reset_release_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            din = exp_w[i]; din_vld = 1'b1;
            tick();
        end
        n_checks++;
        if (count !== 5'd3) begin
            n_fail++; $display("FAIL basic_count3: got %0d expected 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            bus.rdReg = 1'b1; bus.op_sel = 11'h001;
            #1;
            n_checks++;
            if (bus.par_out !== exp_w[i]) begin
                n_fail++; $display("FAIL basic_pop%0d: got %h expected %h", i, bus.par_out, exp_w[i]);
            end
            tick();
        end
        n_checks++;
        if (count !== 5'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL basic_drained: count %0d irq %b expected 0 0", count, irq);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 17; k++) begin
            din = 16'(k); din_vld = 1'b1;
            tick();
        end
        n_checks++;
        if (count !== 5'd16 || irq !== 1'b1) begin
            n_fail++; $display("FAIL ovf_count: count %0d irq %b expected 16 1", count, irq);
        end
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h8010) begin
            n_fail++; $display("FAIL ovf_status: got %h expected 8010", bus.par_out);
        end
        tick();
        for (int k = 0; k < 16; k++) begin
            bus.rdReg = 1'b1; bus.op_sel = 11'h001;
            #1;
            n_checks++;
            if (bus.par_out !== 16'(k)) begin
                n_fail++; $display("FAIL ovf_pop%0d: got %h expected %h", k, bus.par_out, 16'(k));
            end
            tick();
        end
        bus.rdReg = 1'b1; bus.op_sel = 11'h001;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL ovf_17th_absent: got %h expected 0000", bus.par_out);
        end
        tick();
        bus.wrReg = 1'b1; bus.op_sel = 11'h001; bus.tos = 16'h0001;
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL ovf_cleared_status: got %h expected 0000", bus.par_out);
        end
        tick();
    endtask

    task automatic test_push_pop_empty();
        din = 16'hABCD; din_vld = 1'b1;
        bus.rdReg = 1'b1; bus.op_sel = 11'h001;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL empty_pop_par: got %h expected 0000", bus.par_out);
        end
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h4001 || count !== 5'd1) begin
            n_fail++; $display("FAIL empty_pop_status: got %h count %0d expected 4001 count 1", bus.par_out, count);
        end
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h001;
        #1;
        n_checks++;
        if (bus.par_out !== 16'hABCD) begin
            n_fail++; $display("FAIL empty_pop_next: got %h expected abcd", bus.par_out);
        end
        tick();
        bus.wrReg = 1'b1; bus.op_sel = 11'h001; bus.tos = 16'h0001;
        tick();
    endtask

    task automatic test_serial();
        logic exp_b;
        snap = 64'h8000_0000_0000_0001;
        bus.wrEvt = 1'b1; bus.op_sel = 11'h001;
        tick();
        for (int i = 0; i < 64; i++) begin
            bus.rdBit = 1'b1;
            #1;
            exp_b = (i == 0 || i == 63) ? 1'b1 : 1'b0;
            n_checks++;
            if (bus.ser_out !== exp_b) begin
                n_fail++; $display("FAIL serial_bit%0d: got %b expected %b", i, bus.ser_out, exp_b);
            end
            tick();
        end
        bus.rdBit = 1'b1;
        #1;
        n_checks++;
        if (bus.ser_out !== 1'b0) begin
            n_fail++; $display("FAIL serial_65th: got %b expected 0", bus.ser_out);
        end
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h2000) begin
            n_fail++; $display("FAIL serial_sunf_status: got %h expected 2000", bus.par_out);
        end
        tick();
        bus.wrReg = 1'b1; bus.op_sel = 11'h001; bus.tos = 16'h0001;
        tick();
        // load while a serial read is in flight: old bit shown, new word kept
        snap = 64'h8000_0000_0000_0000;
        bus.wrEvt = 1'b1; bus.op_sel = 11'h001;
        tick();
        snap = 64'h4000_0000_0000_0000;
        bus.wrEvt = 1'b1; bus.op_sel = 11'h001; bus.rdBit = 1'b1;
        #1;
        n_checks++;
        if (bus.ser_out !== 1'b1) begin
            n_fail++; $display("FAIL serial_load_preview: got %b expected 1", bus.ser_out);
        end
        tick();
        #1;
        n_checks++;
        if (bus.ser_out !== 1'b0) begin
            n_fail++; $display("FAIL serial_load_wins0: got %b expected 0", bus.ser_out);
        end
        bus.rdBit = 1'b1;
        tick();
        #1;
        n_checks++;
        if (bus.ser_out !== 1'b1) begin
            n_fail++; $display("FAIL serial_load_wins1: got %b expected 1", bus.ser_out);
        end
    endtask

    task automatic test_irq_flush();
        for (int k = 0; k < 7; k++) begin
            din = 16'h0100 + 16'(k); din_vld = 1'b1;
            tick();
        end
        n_checks++;
        if (irq !== 1'b0 || count !== 5'd7) begin
            n_fail++; $display("FAIL irq_below: irq %b count %0d expected 0 7", irq, count);
        end
        din = 16'h0107; din_vld = 1'b1;
        tick();
        n_checks++;
        if (irq !== 1'b1 || count !== 5'd8) begin
            n_fail++; $display("FAIL irq_at_level: irq %b count %0d expected 1 8", irq, count);
        end
        bus.rdReg = 1'b1; bus.op_sel = 11'h004;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL unselected_par: got %h expected 0000", bus.par_out);
        end
        tick();
        n_checks++;
        if (count !== 5'd8) begin
            n_fail++; $display("FAIL unselected_count: got %0d expected 8", count);
        end
        bus.wrReg = 1'b1; bus.op_sel = 11'h001; bus.tos = 16'h0002;
        din = 16'hDEAD; din_vld = 1'b1;
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (count !== 5'd0 || irq !== 1'b0 || bus.par_out !== 16'h0000) begin
            n_fail++; $display("FAIL flush: count %0d irq %b status %h expected 0 0 0000", count, irq, bus.par_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            din = 16'h0501 + 16'(k); din_vld = 1'b1;
            tick();
        end
        snap = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.wrEvt = 1'b1; bus.op_sel = 11'h001;
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h001;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0501 || bus.ser_out !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: par %h ser %b expected 0501 1", bus.par_out, bus.ser_out);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (count !== 5'd0 || bus.ser_out !== 1'b0 || bus.par_out !== 16'h0000 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: count %0d ser %b par %h irq %b expected 0 0 0000 0", count, bus.ser_out, bus.par_out, irq);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        bus.rdReg = 1'b1; bus.op_sel = 11'h002;
        #1;
        n_checks++;
        if (bus.par_out !== 16'h0000 || bus.ser_out !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: status %h ser %b expected 0000 0", bus.par_out, bus.ser_out);
        end
        tick();
    endtask

    initial begin
        rst  = 1'b0;
        din  = 16'h0000;
        snap = 64'h0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_empty();
        test_serial();
        test_irq_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
